// File: rtl/fixed_to_float.sv
// -----------------------------------------------------------------------------
// fixed_to_float
//
// Converts a signed two's-complement fixed-point value (default Q2.30) into an
// IEEE-754 single-precision word. One conversion is in flight at a time. The
// datapath takes the magnitude, normalises it, then rounds to nearest with
// ties to even.
//
// Optional build macro: FIXED_TO_FLOAT_BARREL_EN
//   undefined : NORM shifts left one bit per cycle (lz+1 cycles).
//   defined   : NORM finds the leading-zero count with a priority encoder and
//               barrel-shifts in a single cycle. out_data is bit-identical;
//               only the latency differs.
//
// Parameters
//   DATA_W : fixed-point width including sign bit (8..64)
//   FRAC_W : number of fractional bits (FRAC_W < DATA_W)
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous reset, active low
//   in_valid  : in_data is valid
//   in_ready  : block is idle and can accept input
//   in_data   : signed fixed-point input
//   out_valid : out_data holds a completed result
//   out_ready : consumer accepts out_data
//   out_data  : IEEE-754 single {sign, exp[7:0], man[22:0]}
// -----------------------------------------------------------------------------
module fixed_to_float #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data
);

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        NORM,
        ROUND,
        DONE
    } state_t;

    // Exponent of the MSB position of the raw input word before normalising.
    localparam logic signed [9:0] EXP_INIT = 10'(127 + DATA_W - 1 - FRAC_W);

    // Bits below the hidden one, padded with zeros so that 23 mantissa bits,
    // a guard bit and at least one sticky bit always exist.
    localparam int EXT_W = (DATA_W - 1 > 25) ? DATA_W - 1 : 25;

    state_t            state;
    state_t            state_next;

    logic [DATA_W-1:0] data_q;
    logic              sign_q;
    logic [DATA_W-1:0] mag_q;
    logic signed [9:0] exp_q;

    logic [DATA_W-1:0] mag_abs;
    logic [EXT_W-1:0]  ext;
    logic [22:0]       man_trunc;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       man_sum;
    logic [22:0]       man_rnd;
    logic [7:0]        exp_rnd;

`ifdef FIXED_TO_FLOAT_BARREL_EN
    localparam int LZ_W = $clog2(DATA_W);
    logic [LZ_W-1:0]   lz;

    // Scanning upward lets the highest set bit win. NORM is only entered with
    // a non-zero magnitude, so the all-zero case never matters.
    always_comb begin
        lz = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (mag_q[i]) begin
                lz = LZ_W'(DATA_W - 1 - i);
            end
        end
    end
`endif

    assign in_ready = (state == IDLE);

    // Two's-complement magnitude; the most negative input maps to
    // 2^(DATA_W-1), which still fits as an unsigned DATA_W-bit value.
    assign mag_abs = data_q[DATA_W-1] ? (~data_q + DATA_W'(1)) : data_q;

    // Rounding path: mag_q is normalised (MSB set) whenever ROUND uses it.
    always_comb begin
        ext = '0;
        ext[EXT_W-1 -: DATA_W-1] = mag_q[DATA_W-2:0];
    end

    assign man_trunc = ext[EXT_W-1 -: 23];
    assign guard     = ext[EXT_W-24];
    assign sticky    = |ext[EXT_W-25:0];
    assign round_up  = guard && (sticky || man_trunc[0]);
    assign man_sum   = {1'b0, man_trunc} + 24'(round_up);
    // A carry out of the mantissa leaves man_sum[22:0] all zero, which is
    // exactly the renormalised mantissa; only the exponent needs the bump.
    assign man_rnd   = man_sum[22:0];
    assign exp_rnd   = exp_q[7:0] + 8'(man_sum[23]);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (in_valid) state_next = ABS;
            ABS:   state_next = (data_q == '0) ? DONE : NORM;
`ifdef FIXED_TO_FLOAT_BARREL_EN
            NORM:  state_next = ROUND;
`else
            NORM:  if (mag_q[DATA_W-1]) state_next = ROUND;
`endif
            ROUND: state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // NOTE: every datapath register is cleared by rst_n so a conversion cut
    // short by reset leaves no partial result or stale valid behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            exp_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) data_q <= in_data;
                end
                ABS: begin
                    sign_q <= data_q[DATA_W-1];
                    mag_q  <= mag_abs;
                    exp_q  <= EXP_INIT;
                    // Zero has no leading one; emit +0.0 directly.
                    if (data_q == '0) begin
                        out_data  <= 32'h0000_0000;
                        out_valid <= 1'b1;
                    end
                end
                NORM: begin
`ifdef FIXED_TO_FLOAT_BARREL_EN
                    mag_q <= mag_q << lz;
                    exp_q <= exp_q - 10'(lz);
`else
                    if (!mag_q[DATA_W-1]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 10'sd1;
                    end
`endif
                end
                ROUND: begin
                    out_data  <= {sign_q, exp_rnd, man_rnd};
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float.sv
// -----------------------------------------------------------------------------
// tb_fixed_to_float
//
// Directed bench for fixed_to_float (DATA_W=32, FRAC_W=30). Expected words and
// latencies are hand-derived. Honours FIXED_TO_FLOAT_BARREL_EN for latency.
// -----------------------------------------------------------------------------
module tb_fixed_to_float;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_vec;
    int n_err;

    fixed_to_float #(
        .DATA_W(32),
        .FRAC_W(30)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [31:0] dout;
        int          lz;
    } vec_t;

    function automatic int exp_latency(input logic [31:0] d, input int lz);
        if (d == 32'h0) return 1;
`ifdef FIXED_TO_FLOAT_BARREL_EN
        return 3;
`else
        return lz + 3;
`endif
    endfunction

    // Present one word for a single cycle; returns 1 if in_ready was high.
    task automatic accept(input logic [31:0] d, output logic was_ready);
        was_ready = in_ready;
        in_data   = d;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    // Count cycles after the acceptance edge until out_valid, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: out_valid=%b out_data=%h, want 0/00000000", out_valid, out_data);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_conversions();
        vec_t vecs[10];
        logic rdy;
        int   cyc;
        int   lat;
        vecs[0] = '{"pos_one",    32'h4000_0000, 32'h3F80_0000, 1};
        vecs[1] = '{"neg_one",    32'hC000_0000, 32'hBF80_0000, 1};
        vecs[2] = '{"most_neg",   32'h8000_0000, 32'hC000_0000, 0};
        vecs[3] = '{"zero",       32'h0000_0000, 32'h0000_0000, 0};
        vecs[4] = '{"half_pi",    32'h6487_ED51, 32'h3FC9_0FDB, 1};
        vecs[5] = '{"lsb",        32'h0000_0001, 32'h3080_0000, 31};
        vecs[6] = '{"neg_lsb",    32'hFFFF_FFFF, 32'hB080_0000, 31};
        vecs[7] = '{"tie_even",   32'h4000_0040, 32'h3F80_0000, 1};
        vecs[8] = '{"tie_odd",    32'h4000_00C0, 32'h3F80_0002, 1};
        vecs[9] = '{"man_carry",  32'h7FFF_FFFF, 32'h4000_0000, 1};
        foreach (vecs[i]) begin
            accept(vecs[i].din, rdy);
            n_vec++;
            if (rdy !== 1'b1) begin
                n_err++;
                $display("FAIL %s_ready: in_ready=%b, want 1", vecs[i].name, rdy);
            end
            wait_valid(cyc);
            lat = exp_latency(vecs[i].din, vecs[i].lz);
            n_vec++;
            if (cyc !== lat) begin
                n_err++;
                $display("FAIL %s_latency: got %0d cycles, want %0d", vecs[i].name, cyc, lat);
            end
            n_vec++;
            if (out_data !== vecs[i].dout) begin
                n_err++;
                $display("FAIL %s_data: got %h, want %h", vecs[i].name, out_data, vecs[i].dout);
            end
            handshake();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== vecs[i].dout) begin
                n_err++;
                $display("FAIL %s_handshake: out_valid=%b in_ready=%b out_data=%h, want 0/1/%h",
                         vecs[i].name, out_valid, in_ready, out_data, vecs[i].dout);
            end
        end
    endtask

    task automatic test_backpressure();
        logic rdy;
        int   cyc;
        int   bad;
        accept(32'h4000_0000, rdy);
        wait_valid(cyc);
        // A second request while busy must be ignored.
        in_data  = 32'h1234_5678;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || in_ready !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold: %0d unstable cycles (last out_valid=%b out_data=%h in_ready=%b), want 0",
                     bad, out_valid, out_data, in_ready);
        end
        in_valid = 1'b0;
        handshake();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_no_capture: %0d busy cycles after release, want 0", bad);
        end
        accept(32'hC000_0000, rdy);
        wait_valid(cyc);
        n_vec++;
        if (rdy !== 1'b1 || out_data !== 32'hBF80_0000) begin
            n_err++;
            $display("FAIL bp_next: ready=%b out_data=%h, want 1/BF800000", rdy, out_data);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        logic rdy;
        int   cyc;
        int   bad;
        accept(32'h0000_0001, rdy);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%b out_data=%h in_ready=%b, want 0/00000000/1",
                     out_valid, out_data, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL mid_discard: out_valid high %0d cycles, want 0", bad);
        end
        accept(32'h4000_0000, rdy);
        wait_valid(cyc);
        n_vec++;
        if (out_data !== 32'h3F80_0000 || cyc !== exp_latency(32'h4000_0000, 1)) begin
            n_err++;
            $display("FAIL mid_recover: out_data=%h lat=%0d, want 3F800000 lat=%0d",
                     out_data, cyc, exp_latency(32'h4000_0000, 1));
        end
        handshake();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_conversions();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
